// File: rtl/sdram_arbiter_pkg.sv
// lm80c_mem_pkg: shared widths, owner/state enums and the latched-access record
// for the SDRAM arbiter slice.
// Latency: n/a (types only). Backpressure: n/a.
package lm80c_mem_pkg;

   localparam int ADDR_W     = 25;  // SDRAM byte address width
   localparam int DATA_W     = 8;   // SDRAM data width
   localparam int CPU_ADDR_W = 16;  // Z80 address width
   localparam int STARVE_W   = 4;   // starvation counter width (saturates at 15)

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_DL,
      OWN_ER,
      OWN_CPU
   } owner_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD,
      DONE
   } arb_state_t;

   // One access as latched at the arbitration slot.
   typedef struct packed {
      owner_t              own;
      logic                wr;
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   din;
   } access_t;

   // Z80 addresses sit at the bottom of the SDRAM byte space.
   function automatic logic [ADDR_W-1:0] cpu_addr_ext(input logic [CPU_ADDR_W-1:0] a);
      return {{(ADDR_W-CPU_ADDR_W){1'b0}}, a};
   endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundles the three requester ports, the slot strobe and the
// sdram-side bus. master = requesters + sdram module, slave = arbiter.
// Ports: slot_stb, dl_*/er_* write requests, cpu_* read/write, sd_* to/from sdram.
interface sdram_arbiter_if;
   import lm80c_mem_pkg::*;

   logic                    slot_stb;

   logic                    dl_req;
   logic [ADDR_W-1:0]       dl_addr;
   logic [DATA_W-1:0]       dl_din;
   logic                    dl_ack;

   logic                    er_req;
   logic [ADDR_W-1:0]       er_addr;
   logic [DATA_W-1:0]       er_din;
   logic                    er_ack;

   logic                    cpu_rd;
   logic                    cpu_wr;
   logic [CPU_ADDR_W-1:0]   cpu_addr;
   logic [DATA_W-1:0]       cpu_din;
   logic [DATA_W-1:0]       cpu_dout;
   logic                    cpu_ack;
   logic                    cpu_wait;
   logic                    cpu_starved;

   logic [ADDR_W-1:0]       sd_addr;
   logic [DATA_W-1:0]       sd_din;
   logic                    sd_we;
   logic                    sd_oe;
   logic [DATA_W-1:0]       sd_dout;

   modport master (
      output slot_stb,
      output dl_req, dl_addr, dl_din,
      output er_req, er_addr, er_din,
      output cpu_rd, cpu_wr, cpu_addr, cpu_din,
      output sd_dout,
      input  dl_ack, er_ack,
      input  cpu_dout, cpu_ack, cpu_wait, cpu_starved,
      input  sd_addr, sd_din, sd_we, sd_oe
   );

   modport slave (
      input  slot_stb,
      input  dl_req, dl_addr, dl_din,
      input  er_req, er_addr, er_din,
      input  cpu_rd, cpu_wr, cpu_addr, cpu_din,
      input  sd_dout,
      output dl_ack, er_ack,
      output cpu_dout, cpu_ack, cpu_wait, cpu_starved,
      output sd_addr, sd_din, sd_we, sd_oe
   );

endinterface

// File: rtl/sdram_arbiter_prio_enc.sv
// sdram_prio_enc: fixed-priority owner select, downloader > eraser > CPU.
// Latency: purely combinational. Backpressure: none, losers simply keep requesting.
// Ports: dl_req, er_req, cpu_req in; owner out (OWN_NONE when nobody asks).
module sdram_prio_enc
   import lm80c_mem_pkg::*;
(
   input  logic   dl_req,
   input  logic   er_req,
   input  logic   cpu_req,
   output owner_t owner
);

   always_comb begin
      owner = OWN_NONE;
      if (dl_req)
         owner = OWN_DL;
      else if (er_req)
         owner = OWN_ER;
      else if (cpu_req)
         owner = OWN_CPU;
   end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single 8-bit SDRAM port between downloader, eraser and Z80.
// Latency: write ack 2 cycles after slot_stb, CPU read ack RD_LAT+1 cycles after slot_stb.
// Backpressure: one access per slot; losers hold req, the CPU is held via cpu_wait.
// Ports: sys_clock, res_n (async active-low), bus (sdram_arbiter_if.slave).
module sdram_arbiter
   import lm80c_mem_pkg::*;
#(
   parameter int RD_LAT         = 4,   // cycles from slot_stb to valid sd_dout (>= 2)
   parameter int CPU_STARVE_MAX = 15   // starved slots tolerated before cpu_starved
) (
   input  logic           sys_clock,
   input  logic           res_n,
   sdram_arbiter_if.slave bus
);

   // WAIT_RD lasts RD_LAT-1 cycles, counted 0 .. RD_LAT-2.
   localparam int                  LAT_W      = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
   localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(RD_LAT - 2);
   localparam logic [STARVE_W-1:0] STARVE_SAT = '1;

   arb_state_t            state, state_nxt;
   access_t               acc_q, acc_sel;
   owner_t                win;
   logic [LAT_W-1:0]      lat_cnt;
   logic [DATA_W-1:0]     cpu_dout_q;
   logic [STARVE_W-1:0]   starve_cnt;
   logic                  starved_q;
   logic                  cpu_done_q;
   logic                  armed_q;

   logic                  cpu_req;
   logic                  cpu_req_eff;
   logic                  arb_go;
   logic                  lat_done;

   logic                  sd_we_c, sd_oe_c;
   logic                  dl_ack_c, er_ack_c, cpu_ack_c;

   // A CPU request that was already acked stays blocked until the Z80 drops it,
   // otherwise a level request still high after ack would be served twice.
   assign cpu_req     = bus.cpu_rd | bus.cpu_wr;
   assign cpu_req_eff = cpu_req & ~cpu_done_q;

   sdram_prio_enc u_prio (
      .dl_req  (bus.dl_req),
      .er_req  (bus.er_req),
      .cpu_req (cpu_req_eff),
      .owner   (win)
   );

   // Requests are only looked at on a slot strobe while idle; strobes that land
   // mid-access are dropped and the requester waits for the next slot.
   assign arb_go   = (state == IDLE) && bus.slot_stb && (win != OWN_NONE);
   assign lat_done = (state == WAIT_RD) && (lat_cnt == LAT_LAST);

   // Access selected by the current winner; latched on arb_go.
   always_comb begin
      acc_sel = '0;
      case (win)
         OWN_DL: begin
            acc_sel.own  = OWN_DL;
            acc_sel.wr   = 1'b1;
            acc_sel.addr = bus.dl_addr;
            acc_sel.din  = bus.dl_din;
         end
         OWN_ER: begin
            acc_sel.own  = OWN_ER;
            acc_sel.wr   = 1'b1;
            acc_sel.addr = bus.er_addr;
            acc_sel.din  = bus.er_din;
         end
         OWN_CPU: begin
            acc_sel.own  = OWN_CPU;
            // rd and wr together count as a write
            acc_sel.wr   = bus.cpu_wr;
            acc_sel.addr = cpu_addr_ext(bus.cpu_addr);
            acc_sel.din  = bus.cpu_din;
         end
         default: acc_sel = '0;
      endcase
   end

   always_ff @(posedge sys_clock or negedge res_n) begin
      if (!res_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and strobes; every output is decoded from registered state.
   always_comb begin
      state_nxt = state;
      sd_we_c   = 1'b0;
      sd_oe_c   = 1'b0;
      dl_ack_c  = 1'b0;
      er_ack_c  = 1'b0;
      cpu_ack_c = 1'b0;
      case (state)
         IDLE: begin
            if (arb_go)
               state_nxt = ISSUE;
         end
         ISSUE: begin
            sd_we_c   = acc_q.wr;
            sd_oe_c   = ~acc_q.wr;
            state_nxt = acc_q.wr ? DONE : WAIT_RD;
         end
         WAIT_RD: begin
            if (lat_done)
               state_nxt = DONE;
         end
         DONE: begin
            dl_ack_c  = (acc_q.own == OWN_DL);
            er_ack_c  = (acc_q.own == OWN_ER);
            cpu_ack_c = (acc_q.own == OWN_CPU);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clock or negedge res_n) begin
      if (!res_n) begin
         acc_q      <= '0;
         lat_cnt    <= '0;
         cpu_dout_q <= '0;
         starve_cnt <= '0;
         starved_q  <= 1'b0;
         cpu_done_q <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         armed_q <= 1'b1;

         // Later changes of address/data on a held request are not seen.
         if (arb_go)
            acc_q <= acc_sel;

         if (state == ISSUE)
            lat_cnt <= '0;
         else if (state == WAIT_RD)
            lat_cnt <= lat_cnt + 1'b1;

         if (lat_done)
            cpu_dout_q <= bus.sd_dout;

         // Counter saturates at 15; the flag fires on the starved slot that
         // would have pushed the count past CPU_STARVE_MAX.
         if (arb_go) begin
            if (win == OWN_CPU) begin
               starve_cnt <= '0;
            end else if (cpu_req_eff) begin
               if (int'(starve_cnt) >= CPU_STARVE_MAX)
                  starved_q <= 1'b1;
               if (starve_cnt != STARVE_SAT)
                  starve_cnt <= starve_cnt + 1'b1;
            end
         end

         if (cpu_ack_c)
            cpu_done_q <= 1'b1;
         else if (!cpu_req)
            cpu_done_q <= 1'b0;
      end
   end

   assign bus.sd_addr     = acc_q.addr;
   assign bus.sd_din      = acc_q.din;
   assign bus.sd_we       = sd_we_c;
   assign bus.sd_oe       = sd_oe_c;
   assign bus.dl_ack      = dl_ack_c;
   assign bus.er_ack      = er_ack_c;
   assign bus.cpu_ack     = cpu_ack_c;
   assign bus.cpu_dout    = cpu_dout_q;
   assign bus.cpu_starved = starved_q;
   // High through the ack cycle, low from the cycle after; armed_q keeps it
   // low while in reset and for the first cycle after release.
   assign bus.cpu_wait    = cpu_req & ~cpu_done_q & armed_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Registered arbiter that shares the single 8-bit SDRAM port between three requesters: ROM/PRG downloader, memory eraser and Z80 CPU. It replaces the combinational address/data/we/oe mux in the top level. One access is issued per SDRAM slot, with fixed priority and per-requester acknowledge, and the CPU is held in WAIT while it is not being served. It sits between those masters and the sdram module, in the sys_clock domain.

Parameters:
ADDR_W, 25, SDRAM byte address width
DATA_W, 8, data width
RD_LAT, 4, sys_clock cycles from slot_stb to valid sd_dout
CPU_STARVE_MAX, 15, consecutive CPU-starved slots before cpu_starved flag is raised

Ports:
sys_clock  in  1  system clock (same clock as the sdram module)
res_n  in  1  asynchronous active-low reset
slot_stb  in  1  one-cycle pulse at start of each SDRAM slot (aligned to clkref)
dl_req  in  1  downloader request, level, held until dl_ack
dl_addr  in  ADDR_W  downloader address
dl_din  in  DATA_W  downloader write data (downloader only writes)
dl_ack  out  1  one-cycle pulse when the write is issued
er_req  in  1  eraser request, level
er_addr  in  ADDR_W  eraser address
er_din  in  DATA_W  eraser write data
er_ack  out  1  one-cycle write-done pulse
cpu_rd  in  1  CPU read request, level
cpu_wr  in  1  CPU write request, level
cpu_addr  in  16  CPU address, zero-extended to ADDR_W
cpu_din  in  DATA_W  CPU write data
cpu_dout  out  DATA_W  registered CPU read data
cpu_ack  out  1  one-cycle pulse when the access completes (read data valid)
cpu_wait  out  1  high while a CPU request is pending and not yet acked
cpu_starved  out  1  sticky flag: CPU_STARVE_MAX exceeded; cleared by reset only
sd_addr  out  ADDR_W  to sdram.addr
sd_din  out  DATA_W  to sdram.din
sd_we  out  1  to sdram.we
sd_oe  out  1  to sdram.oe
sd_dout  in  DATA_W  from sdram.dout

Behaviour:
- Reset (async, res_n=0): state IDLE. All acks 0, sd_we 0, sd_oe 0, sd_addr 0, sd_din 0, cpu_dout 0, cpu_wait 0, cpu_starved 0, starve counter 0.
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE: arbitration happens only on a slot_stb cycle. Fixed priority dl > er > cpu. The grant, address, data and direction are latched into registers. The next state is ISSUE.
- Requests are sampled only on slot_stb. If no request is present, stay in IDLE and do not drive sd_we or sd_oe.
- ISSUE, held for 1 cycle:
  - sd_addr and sd_din are driven from the latched values.
  - Write: sd_we=1, sd_oe=0.
  - Read: sd_oe=1, sd_we=0.
  - Write goes to DONE. Read goes to WAIT_RD.
- WAIT_RD: count RD_LAT-1 cycles, then capture sd_dout into cpu_dout. Go to DONE.
- DONE: pulse the granted ack for exactly 1 cycle. sd_we and sd_oe fall to 0. Return to IDLE.
- Latency:
  - CPU read: cpu_ack arrives RD_LAT+1 cycles after slot_stb.
  - Write: ack arrives 2 cycles after slot_stb.
- At most one access per slot. A slot_stb that arrives while not in IDLE is ignored; the requester waits for the next slot.
- cpu_wait is combinational: (cpu_rd|cpu_wr) & ~cpu_ack_pending_done. It is high from request assertion until the cycle after cpu_ack.
- cpu_rd and cpu_wr asserted together: treated as a write.
- Starvation:
  - The counter increments on each slot_stb where a CPU request is pending but dl or er wins.
  - It resets to 0 when the CPU is granted.
  - It saturates at 2^4-1.
  - cpu_starved sets when the counter exceeds CPU_STARVE_MAX.
- Request dropped before its ack: the latched access still completes. The ack is still pulsed and masters must ignore it.
- A requester asserting req again in the cycle right after its ack is legal and is arbitrated at the next slot_stb.
- An address change while req is held has no effect once the access has been latched.

Decomposition:
- Package lm80c_mem_pkg:
  - typedef enum owner_t {OWN_NONE, OWN_DL, OWN_ER, OWN_CPU}
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT_RD, DONE}
  - ADDR_W and DATA_W localparams
- One sub-module is natural: sdram_prio_enc, a pure fixed-priority encoder that takes the three requests and returns owner_t. The FSM and the starve counter stay in the top of sdram_arbiter.

Test Plan:
- CPU read alone: preload mem[0x8241]=0xA5, cpu_rd at slot_stb → sd_oe=1 for 1 cycle, cpu_ack at slot_stb+RD_LAT+1, cpu_dout=0xA5, cpu_wait drops next cycle.
- dl_req and cpu_wr raised in the same slot: dl addr 0x0000 data 0x3E, cpu addr 0x9000 data 0x11 → dl_ack in this slot. CPU write is issued next slot; cpu_wait high across both slots. Memory holds 0x3E and 0x11.
- er_req and dl_req both held for 3 slots → dl_ack only, er_ack never pulses. Drop dl_req → er_ack on the next slot.
- CPU starved for 16 consecutive slots by er_req → cpu_starved=1 and stays 1 after er_req drops. After the CPU is served the counter is 0 while the flag remains.
- slot_stb pulsed again during WAIT_RD → ignored. The current read completes and no second sd_oe pulse appears in that window.
- res_n pulled low mid-WAIT_RD → all outputs 0 immediately (async). After release the state is IDLE and there is no spurious cpu_ack.
